// File: rtl/mcu_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_timer_pkg
//  Description : Register indices, CTRL/STAT bit positions and helpers shared
//                by the MCU timer RTL, its bench and the firmware header
//                generator.
//  Revision    : 1.0  initial release
// ============================================================================
package mcu_timer_pkg;

    // Register indices (CPU_AB[2:0])
    localparam logic [2:0] c_addr_ctrl   = 3'd0;
    localparam logic [2:0] c_addr_stat   = 3'd1;
    localparam logic [2:0] c_addr_rld_lo = 3'd2;
    localparam logic [2:0] c_addr_rld_hi = 3'd3;
    localparam logic [2:0] c_addr_cnt_lo = 3'd4;
    localparam logic [2:0] c_addr_cnt_hi = 3'd5;
    localparam logic [2:0] c_addr_presc  = 3'd6;
    localparam logic [2:0] c_addr_rsvd   = 3'd7;

    // CTRL bit positions
    localparam int c_ctrl_en_bit   = 0;
    localparam int c_ctrl_auto_bit = 1;
    localparam int c_ctrl_ie_bit   = 2;

    // STAT bit positions
    localparam int c_stat_tf_bit   = 0;

    // Software-visible control bits
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } ctrl_t;

    // CTRL read-back image; unused upper bits read as zero
    function automatic logic [7:0] ctrl_byte(input ctrl_t c);
        logic [7:0] v;
        v                  = 8'h00;
        v[c_ctrl_en_bit]   = c.en;
        v[c_ctrl_auto_bit] = c.auto_rl;
        v[c_ctrl_ie_bit]   = c.ie;
        return v;
    endfunction

endpackage : mcu_timer_pkg
`default_nettype wire

// File: rtl/mcu_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_timer_prescaler
//  Description : 8-bit prescaler counting 0..presc while enabled, emitting a
//                one-cycle tick on the terminal count. Held at 0 when idle.
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] r_pcnt;
    logic       w_wrap;

    // ">=" rather than "==" so a PRESC lowered below the running count wraps
    // immediately instead of running through 255.
    assign w_wrap = (r_pcnt >= presc);
    assign tick   = en & w_wrap;

    // Prescale counter: cleared when disabled or on wrap, else counts up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= 8'h00;
        end else if (!en || w_wrap) begin
            r_pcnt <= 8'h00;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

endmodule : mcu_timer_prescaler
`default_nettype wire

// File: rtl/mcu_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_timer
//  Description : CPU-mapped 16-bit down-counting timer with 8-bit prescaler,
//                one-shot / auto-reload modes, snapshot counter read and a
//                level interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_timer
    import mcu_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000  // informational only
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    ctrl_t       r_ctrl;
    logic        r_tf;
    logic [15:0] r_rld;
    logic [7:0]  r_stage;
    logic [15:0] r_cnt;
    logic [7:0]  r_snap;
    logic [7:0]  r_presc;

    logic        w_wr;
    logic        w_rd;
    logic        w_commit;
    logic        w_tick;
    logic        w_expire;
    logic        w_pre_en;

    assign w_wr     = cs & we;
    assign w_rd     = cs & ~we;
    assign w_commit = w_wr && (addr == c_addr_rld_hi);
    assign w_expire = w_tick && (r_cnt == 16'h0000);

    // Masking the enable on a reload commit restarts the prescale phase at 0
    assign w_pre_en = r_ctrl.en & ~w_commit;

    mcu_timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (w_pre_en),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // Control, flag and prescale-value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_tf    <= 1'b0;
            r_presc <= 8'h00;
        end else begin
            if (w_expire && !r_ctrl.auto_rl) begin
                r_ctrl.en <= 1'b0;
            end
            // A CPU write to CTRL overrides a concurrent auto-stop
            if (w_wr && (addr == c_addr_ctrl)) begin
                r_ctrl.en      <= din[c_ctrl_en_bit];
                r_ctrl.auto_rl <= din[c_ctrl_auto_bit];
                r_ctrl.ie      <= din[c_ctrl_ie_bit];
            end
            if (w_wr && (addr == c_addr_stat) && din[c_stat_tf_bit]) begin
                r_tf <= 1'b0;
            end
            // Set wins over a same-cycle software clear
            if (w_expire) begin
                r_tf <= 1'b1;
            end
            if (w_wr && (addr == c_addr_presc)) begin
                r_presc <= din;
            end
        end
    end

    // Reload staging/commit and the 16-bit down counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= 8'h00;
            r_rld   <= 16'h0000;
            r_cnt   <= 16'h0000;
        end else begin
            if (w_wr && (addr == c_addr_rld_lo)) begin
                r_stage <= din;
            end
            if (w_commit) begin
                r_rld <= {din, r_stage};
                r_cnt <= {din, r_stage};
            end else if (w_tick) begin
                if (r_cnt != 16'h0000) begin
                    r_cnt <= r_cnt - 16'd1;
                end else if (r_ctrl.auto_rl) begin
                    r_cnt <= r_rld;
                end
            end
        end
    end

    // Registered read mux; a CNT_LO read freezes the high byte for CNT_HI
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= 8'h00;
            r_snap <= 8'h00;
        end else if (w_rd) begin
            case (addr)
                c_addr_ctrl:   dout <= ctrl_byte(r_ctrl);
                c_addr_stat:   dout <= {7'b0, r_tf};
                c_addr_rld_lo: dout <= r_rld[7:0];
                c_addr_rld_hi: dout <= r_rld[15:8];
                c_addr_cnt_lo: begin
                    dout   <= r_cnt[7:0];
                    r_snap <= r_cnt[15:8];
                end
                c_addr_cnt_hi: dout <= r_snap;
                c_addr_presc:  dout <= r_presc;
                default:       dout <= 8'h00;
            endcase
        end
    end

    // Interrupt is a pure function of registered state
    assign irq = r_tf & r_ctrl.ie;

endmodule : mcu_timer
`default_nettype wire

// File: tb/tb_mcu_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_timer
//  Description : Self-checking bench for mcu_timer: table-driven bus vectors,
//                read scoreboard and hand-timed corner-case sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcu_timer;
    import mcu_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    mcu_timer #(.CLK_HZ(12000000)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;  // write data, or expected read data
    } vec_t;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] exp;
    } sb_t;

    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sb_q[$];
    logic r_pend = 1'b0;

    vec_t t_zero[8];
    vec_t t_rsv[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // A read issued at a posedge produces dout valid one cycle later
    always @(posedge clk) r_pend <= cs && !we && !rst;

    always @(negedge clk) begin
        if (r_pend) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%02h, expected no read", dout);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk($sformatf("rd[%0d]", e.addr), dout, e.exp);
            end
        end
    end

    // Bus tasks: entered just after a negedge, return one negedge later
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        sb_t e;
        e.addr = a;
        e.exp  = exp;
        sb_q.push_back(e);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        if (v.we) wr(v.addr, v.data);
        else      rd(v.addr, v.data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector tables ----------------
        for (int i = 0; i < 8; i++) t_zero[i] = '{1'b0, 3'(i), 8'h00};
        t_rsv = '{
            '{1'b1, c_addr_ctrl,   8'h00},
            '{1'b1, c_addr_presc,  8'h02},
            '{1'b1, c_addr_rld_lo, 8'h34},
            '{1'b1, c_addr_rld_hi, 8'h12},
            '{1'b1, c_addr_rsvd,   8'hAA},
            '{1'b1, c_addr_cnt_hi, 8'hAA},
            '{1'b1, c_addr_cnt_lo, 8'hAA},
            '{1'b0, c_addr_rsvd,   8'h00},
            '{1'b0, c_addr_cnt_lo, 8'h34},
            '{1'b0, c_addr_cnt_hi, 8'h12},
            '{1'b0, c_addr_ctrl,   8'h00},
            '{1'b0, c_addr_stat,   8'h00},
            '{1'b0, c_addr_rld_lo, 8'h34},
            '{1'b0, c_addr_rld_hi, 8'h12},
            '{1'b0, c_addr_presc,  8'h02}
        };

        cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00; rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("por_dout", dout, 8'h00);
        chk("por_irq", {7'b0, irq}, 8'h00);
        rst = 1'b0;
        foreach (t_zero[i]) apply(t_zero[i]);

        // ---------------- one-shot ----------------
        wr(c_addr_presc, 8'h00);
        wr(c_addr_rld_lo, 8'hFF);
        wr(c_addr_rld_hi, 8'hFF);      // nonzero counter before enabling
        wr(c_addr_ctrl, 8'h05);
        wr(c_addr_rld_lo, 8'h03);
        wr(c_addr_rld_hi, 8'h00);      // commit at edge 0
        idle(3);
        chk("oneshot_irq_3clk", {7'b0, irq}, 8'h00);
        idle(1);
        chk("oneshot_irq_4clk", {7'b0, irq}, 8'h01);
        rd(c_addr_ctrl, 8'h04);
        rd(c_addr_cnt_lo, 8'h00);
        rd(c_addr_cnt_hi, 8'h00);
        rd(c_addr_stat, 8'h01);
        idle(5);
        chk("oneshot_irq_hold", {7'b0, irq}, 8'h01);
        rd(c_addr_cnt_lo, 8'h00);
        wr(c_addr_stat, 8'h01);
        chk("oneshot_irq_clr", {7'b0, irq}, 8'h00);

        // ---------------- auto-reload + collision ----------------
        wr(c_addr_presc, 8'h02);
        wr(c_addr_rld_lo, 8'h01);
        wr(c_addr_rld_hi, 8'h00);
        wr(c_addr_ctrl, 8'h03);        // enable at edge 0; TF at edges 6,12,18
        idle(4);
        rd(c_addr_stat, 8'h00);        // sampled at edge 5
        rd(c_addr_stat, 8'h00);        // edge 6 sees pre-set value
        rd(c_addr_stat, 8'h01);        // edge 7
        wr(c_addr_stat, 8'h01);        // clear at edge 8
        rd(c_addr_stat, 8'h00);        // edge 9
        idle(2);
        rd(c_addr_stat, 8'h00);        // edge 12 sees pre-set value
        rd(c_addr_stat, 8'h01);        // edge 13
        wr(c_addr_ctrl, 8'h07);        // edge 14, IE on, keeps phase
        chk("auto_irq_ie", {7'b0, irq}, 8'h01);
        idle(3);
        wr(c_addr_stat, 8'h01);        // edge 18: clear collides with set
        chk("collide_irq", {7'b0, irq}, 8'h01);
        rd(c_addr_stat, 8'h01);
        wr(c_addr_stat, 8'h01);
        chk("collide_irq_clr", {7'b0, irq}, 8'h00);

        // ---------------- read latency and snapshot ----------------
        wr(c_addr_ctrl, 8'h00);
        wr(c_addr_presc, 8'h00);
        wr(c_addr_rld_lo, 8'hFF);
        wr(c_addr_rld_hi, 8'h12);
        rd(c_addr_cnt_lo, 8'hFF);
        wr(c_addr_ctrl, 8'h01);        // counts every cycle from 0x12FF
        idle(300);
        rd(c_addr_cnt_hi, 8'h12);      // snapshot survives the rollover
        rd(c_addr_cnt_lo, 8'hD2);      // 0x12FF - 301
        rd(c_addr_cnt_hi, 8'h11);

        // ---------------- reserved / read-only writes ----------------
        foreach (t_rsv[i]) apply(t_rsv[i]);

        // ---------------- reset mid-count ----------------
        wr(c_addr_presc, 8'h00);
        wr(c_addr_rld_lo, 8'h02);
        wr(c_addr_rld_hi, 8'h00);
        wr(c_addr_ctrl, 8'h07);
        idle(10);
        chk("pre_rst_irq", {7'b0, irq}, 8'h01);
        rd(c_addr_rld_lo, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_dout", dout, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        foreach (t_zero[i]) apply(t_zero[i]);
        idle(20);
        chk("rst_irq_stays", {7'b0, irq}, 8'h00);
        rd(c_addr_cnt_lo, 8'h00);

        idle(2);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending reads, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mcu_timer
`default_nettype wire
